display_scan_controller: RTL and testbench

Time-multiplexes one shared 4-bit-to-7-segment decoder across NUM_DIGITS common-anode digits. Holds a tear-free shadow copy of the display value and scans the digits in turn, with a blanking gap before each digit to suppress ghosting. Optionally suppresses leading zeros. Sits between the application logic, which supplies packed BCD, and the registered segment decoder and digit anode drivers.

---
 rtl/display_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Scans NUM_DIGITS common-anode digits through one shared 4-bit to
//   7-segment decoder. A shadow copy of the display value is updated only
//   at frame boundaries, so a frame never mixes old and new digits. Each
//   digit is preceded by a dark gap that hides decoder settling (ghosting).
//
// Ports
//   CLOCK_50     in   system clock
//   reset        in   synchronous, active-high reset
//   load         in   strobe, captures digits_in into the pending register
//   digits_in    in   packed BCD nibbles, nibble 0 = least significant digit
//   blank_zeros  in   1 = show leading zeros as blank
//   digit_code   out  nibble for the decoder, 4'hF = blank
//   digit_en     out  active-low anode enables
//   load_ack     out  one-cycle pulse the cycle after load
//   frame_done   out  one-cycle pulse at each frame boundary
module display_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_zeros,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               counter_q, counter_d;
  logic [IDX_W-1:0]               index_q, index_d;
  logic [NUM_DIGITS-1:0][3:0]     shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]     pending_q, pending_d;
  logic                           pending_valid_q, pending_valid_d;
  logic [3:0]                     digit_code_q, digit_code_d;
  logic [NUM_DIGITS-1:0]          digit_en_q, digit_en_d;
  logic                           load_ack_q, load_ack_d;
  logic                           frame_done_q, frame_done_d;
  logic                           boundary;
  logic                           blank_entry;

  // Nibble actually sent to the decoder for digit idx. A zero is blanked
  // only if every nibble above it is also zero; digit 0 is always shown.
  function automatic logic [3:0] eff_nibble(input logic [NUM_DIGITS-1:0][3:0] v,
                                            input logic [IDX_W-1:0] idx,
                                            input logic bz);
    logic [3:0] res;
    logic       above_zero;
    res        = v[idx];
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (IDX_W'(i) == idx && bz && above_zero && v[i] == 4'h0)
        res = 4'hF;
      above_zero = above_zero & (v[i] == 4'h0);
    end
    return res;
  endfunction

  // State register (also holds datapath flops)
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= BLANK;
      counter_q       <= '0;
      index_q         <= '0;
      shadow_q        <= '1;
      pending_q       <= '1;
      pending_valid_q <= 1'b0;
      digit_code_q    <= 4'hF;
      digit_en_q      <= '1;
      load_ack_q      <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      index_q         <= index_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      digit_code_q    <= digit_code_d;
      digit_en_q      <= digit_en_d;
      load_ack_q      <= load_ack_d;
      frame_done_q    <= frame_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q + CNT_W'(1);
    index_d   = index_q;
    boundary  = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (counter_q == BLANK_LAST) begin
          state_d   = SHOW;
          counter_d = '0;
        end
      end
      SHOW: begin
        if (counter_q == SHOW_LAST) begin
          state_d   = BLANK;
          counter_d = '0;
          if (index_q == IDX_LAST) begin
            index_d  = '0;
            boundary = 1'b1;
          end else begin
            index_d  = index_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign blank_entry = (state_q == SHOW) && (state_d == BLANK);

  // Output / datapath logic
  always_comb begin
    pending_d       = load ? digits_in : pending_q;
    shadow_d        = shadow_q;
    pending_valid_d = pending_valid_q | load;
    if (boundary) begin
      if (pending_valid_q) shadow_d = pending_q;
      // A load on the boundary edge itself stays pending for the next frame
      pending_valid_d = load;
    end

    // The code is chosen from shadow_d so that the first digit of a new
    // frame already reflects the value swapped in on the same edge.
    digit_code_d = digit_code_q;
    if (blank_entry) digit_code_d = eff_nibble(shadow_d, index_d, blank_zeros);

    digit_en_d = '1;
    if (state_d == SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (IDX_W'(i) == index_d) digit_en_d[i] = 1'b0;
    end

    load_ack_d   = load;
    frame_done_d = boundary;
  end

  assign digit_code = digit_code_q;
  assign digit_en   = digit_en_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with NUM_DIGITS=4,
// REFRESH_DIV=8, BLANK_CYCLES=2: 10 cycles per digit, 40-cycle frame.
// Cycle k is observed on the falling edge before rising edge k; inputs
// set during cycle k are sampled by rising edge k.
module tb_display_scan_controller;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic        blank_zeros = 1'b0;
  logic [3:0]  digit_code;
  logic [3:0]  digit_en;
  logic        load_ack;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  display_scan_controller #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .load(load), .digits_in(digits_in),
    .blank_zeros(blank_zeros), .digit_code(digit_code), .digit_en(digit_en),
    .load_ack(load_ack), .frame_done(frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected anode pattern: 2 dark cycles then 8 lit cycles per digit.
  function automatic logic [3:0] exp_en(input int c);
    int p, d;
    p = c % 10;
    d = (c / 10) % 4;
    if (p < 2) return 4'b1111;
    return ~(4'b0001 << d);
  endfunction

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  // Leaves the bench observing cycle 0 (state right after reset).
  task automatic do_reset();
    load = 1'b0;
    blank_zeros = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 46; c++) begin
      checks++;
      if (digit_en !== exp_en(c)) begin
        errors++; $display("FAIL reset_scan_en c=%0d got %b exp %b", c, digit_en, exp_en(c));
      end
      checks++;
      if (digit_code !== 4'hF) begin
        errors++; $display("FAIL reset_code c=%0d got %h exp F", c, digit_code);
      end
      checks++;
      if (frame_done !== (c == 40)) begin
        errors++; $display("FAIL reset_frame_done c=%0d got %b exp %b", c, frame_done, (c == 40));
      end
      checks++;
      if (load_ack !== 1'b0) begin
        errors++; $display("FAIL reset_load_ack c=%0d got %b exp 0", c, load_ack);
      end
      tick();
    end
  endtask

  task automatic test_load();
    logic [15:0] v;
    logic [3:0]  e;
    v = 16'h1234;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      load = (c == 5);
      digits_in = v;
      e = (c < 40) ? 4'hF : v[((c / 10) % 4) * 4 +: 4];
      checks++;
      if (digit_code !== e) begin
        errors++; $display("FAIL load_code c=%0d got %h exp %h", c, digit_code, e);
      end
      checks++;
      if (load_ack !== (c == 6)) begin
        errors++; $display("FAIL load_ack c=%0d got %b exp %b", c, load_ack, (c == 6));
      end
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_blank_zeros();
    logic [15:0] exp_a, exp_b, exp_c;
    logic [3:0]  e;
    int d;
    exp_a = 16'hFF50;  // 0050 suppressed
    exp_b = 16'hFFF0;  // 0000 suppressed
    exp_c = 16'h0050;  // 0050 shown in full
    do_reset();
    blank_zeros = 1'b1;
    for (int c = 0; c < 160; c++) begin
      load = (c == 5) || (c == 45) || (c == 85);
      digits_in = (c == 45) ? 16'h0000 : 16'h0050;
      if (c >= 115) blank_zeros = 1'b0;
      d = (c / 10) % 4;
      if (c >= 40) begin
        if (c < 80)       e = exp_a[d*4 +: 4];
        else if (c < 120) e = exp_b[d*4 +: 4];
        else              e = exp_c[d*4 +: 4];
        checks++;
        if (digit_code !== e) begin
          errors++; $display("FAIL blank_zeros_code c=%0d got %h exp %h", c, digit_code, e);
        end
      end
      tick();
    end
    load = 1'b0;
    blank_zeros = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      load = (c == 5) || (c == 20);
      digits_in = (c == 5) ? 16'h1111 : 16'h2222;
      e = (c < 40) ? 4'hF : 4'h2;
      checks++;
      if (digit_code !== e) begin
        errors++; $display("FAIL b2b_code c=%0d got %h exp %h", c, digit_code, e);
      end
      checks++;
      if (load_ack !== (c == 6 || c == 21)) begin
        errors++; $display("FAIL b2b_load_ack c=%0d got %b exp %b", c, load_ack, (c == 6 || c == 21));
      end
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_boundary_load();
    logic [15:0] v;
    logic [3:0]  e;
    v = 16'h1234;
    do_reset();
    for (int c = 0; c < 90; c++) begin
      load = (c == 5) || (c == 39);
      digits_in = (c == 5) ? v : 16'h7777;
      if (c < 40)      e = 4'hF;
      else if (c < 80) e = v[((c / 10) % 4) * 4 +: 4];
      else             e = 4'h7;
      checks++;
      if (digit_code !== e) begin
        errors++; $display("FAIL boundary_code c=%0d got %h exp %h", c, digit_code, e);
      end
      checks++;
      if (frame_done !== (c == 40 || c == 80)) begin
        errors++; $display("FAIL boundary_frame_done c=%0d got %b exp %b", c, frame_done, (c == 40 || c == 80));
      end
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c < 26; c++) begin
      load = (c == 10);
      digits_in = 16'h5678;
      if (c == 25) begin
        checks++;
        if (digit_en !== 4'b1011) begin
          errors++; $display("FAIL midreset_pre_en got %b exp 1011", digit_en);
        end
        reset = 1'b1;
      end
      tick();
    end
    load = 1'b0;
    checks++;
    if (digit_en !== 4'b1111) begin
      errors++; $display("FAIL midreset_en got %b exp 1111", digit_en);
    end
    checks++;
    if (digit_code !== 4'hF) begin
      errors++; $display("FAIL midreset_code got %h exp F", digit_code);
    end
    reset = 1'b0;
    // Restart: pending 5678 must be gone, so the next frame is still blank.
    for (int c = 0; c < 46; c++) begin
      checks++;
      if (digit_en !== exp_en(c)) begin
        errors++; $display("FAIL midreset_scan_en c=%0d got %b exp %b", c, digit_en, exp_en(c));
      end
      checks++;
      if (digit_code !== 4'hF) begin
        errors++; $display("FAIL midreset_pending c=%0d got %h exp F", c, digit_code);
      end
      checks++;
      if (frame_done !== (c == 40)) begin
        errors++; $display("FAIL midreset_frame_done c=%0d got %b exp %b", c, frame_done, (c == 40));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_blank_zeros();
    test_back_to_back();
    test_boundary_load();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
